pipelined_load_unit: RTL and testbench

//  Read-side counterpart of the pipelined ALU's store path. Accepts load ops
//  (rd, func, addr), reads the synchronous data memory, formats the word,

---
 rtl/pipelined_load_unit.sv | 134 +++++++++++++
 tb/tb_pipelined_load_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_load_unit.sv
// Three-stage load pipeline: issue a synchronous memory read, catch the returned
// word, format it and hand it to the register-bank write port with ready/valid backpressure.
module pipelined_load_unit #(
  parameter int DW = 16,
  parameter int AW = 8,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [RW-1:0] in_rd,
  input  logic [3:0]    in_func,
  input  logic [AW-1:0] in_addr,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_rdata,
  output logic          rf_we,
  output logic [RW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  input  logic          rf_ready,
  output logic          err_illegal,
  output logic [15:0]   load_count
);

  // Result is {illegal, data}; unsupported formats yield illegal with zero data.
  function automatic logic [DW:0] format_load(input logic [3:0] func, input logic [DW-1:0] word);
    logic [DW:0] res;
    res = {(DW+1){1'b0}};
    case (func)
      4'b0000: res = {1'b0, word};
      4'b0001: res = {1'b0, {(DW-8){1'b0}}, word[7:0]};
      4'b0010: res = {1'b0, {(DW-8){1'b0}}, word[15:8]};
      4'b0011: res = {1'b0, {(DW-8){word[7]}}, word[7:0]};
      4'b0100: res = {1'b0, {(DW-8){word[15]}}, word[15:8]};
      default: res = {1'b1, {DW{1'b0}}};
    endcase
    return res;
  endfunction

  logic          v1_r, v2_r, v3_r;
  logic [RW-1:0] rd1_r, rd2_r, rd3_r;
  logic [3:0]    func1_r, func2_r;
  logic [AW-1:0] addr1_r;
  logic [DW-1:0] hold_r, data3_r;
  logic          held_r, ill3_r;
  logic [15:0]   count_r;

  logic          s3_free_s, s2_move_s, s1_move_s;
  logic [DW-1:0] s2_data_s;
  logic [DW:0]   fmt_s;

  // An illegal op never waits on the register bank, so it always frees S3.
  assign s3_free_s = ~v3_r | rf_ready | ill3_r;
  assign s2_move_s = v2_r & s3_free_s;
  assign s1_move_s = v1_r & (~v2_r | s2_move_s);
  assign s2_data_s = held_r ? hold_r : mem_rdata;
  assign fmt_s     = format_load(func2_r, s2_data_s);

  assign in_ready    = ~v1_r | s1_move_s;
  assign mem_rd_en   = s1_move_s;
  assign mem_addr    = addr1_r;
  assign rf_we       = v3_r & ~ill3_r;
  assign rf_waddr    = rd3_r;
  assign rf_wdata    = data3_r;
  assign err_illegal = v3_r & ill3_r;
  assign load_count  = count_r;

  // S1 issue stage: capture accepted ops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_r    <= 1'b0;
      rd1_r   <= {RW{1'b0}};
      func1_r <= 4'b0000;
      addr1_r <= {AW{1'b0}};
    end else if (in_ready) begin
      v1_r <= in_valid;
      if (in_valid) begin
        rd1_r   <= in_rd;
        func1_r <= in_func;
        addr1_r <= in_addr;
      end
    end
  end

  // S2 data-return stage: the read data is only live for one cycle, so a stalled op keeps a copy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v2_r    <= 1'b0;
      rd2_r   <= {RW{1'b0}};
      func2_r <= 4'b0000;
      hold_r  <= {DW{1'b0}};
      held_r  <= 1'b0;
    end else if (s1_move_s) begin
      v2_r    <= 1'b1;
      rd2_r   <= rd1_r;
      func2_r <= func1_r;
      held_r  <= 1'b0;
    end else if (s2_move_s) begin
      v2_r   <= 1'b0;
      held_r <= 1'b0;
    end else if (v2_r && !held_r) begin
      hold_r <= mem_rdata;
      held_r <= 1'b1;
    end
  end

  // S3 writeback stage: formatted result stays put until the register bank takes it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v3_r    <= 1'b0;
      rd3_r   <= {RW{1'b0}};
      data3_r <= {DW{1'b0}};
      ill3_r  <= 1'b0;
    end else if (s3_free_s) begin
      v3_r <= s2_move_s;
      if (s2_move_s) begin
        rd3_r   <= rd2_r;
        data3_r <= fmt_s[DW-1:0];
        ill3_r  <= fmt_s[DW];
      end
    end
  end

  // Completed register writes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_r <= 16'd0;
    end else if (rf_we && rf_ready) begin
      count_r <= count_r + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipelined_load_unit.sv
// Scoreboard bench for pipelined_load_unit: a behavioural synchronous memory feeds the DUT,
// expected writes are queued on accept and compared when the register-bank port fires.
module tb_pipelined_load_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [3:0]  in_rd, in_func;
  logic [7:0]  in_addr;
  logic        mem_rd_en;
  logic [7:0]  mem_addr;
  logic [15:0] mem_rdata;
  logic        rf_we, rf_ready, err_illegal;
  logic [3:0]  rf_waddr;
  logic [15:0] rf_wdata, load_count;

  logic [15:0] mem [0:255];
  logic [20:0] sb [$];
  logic [20:0] e;
  int checks = 0, failures = 0;
  int rd_cnt = 0, we_cnt = 0, err_cnt = 0, run = 0, max_run = 0;

  always #5 clk = ~clk;

  pipelined_load_unit #(.DW(16), .AW(8), .RW(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_func(in_func), .in_addr(in_addr),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_ready(rf_ready),
    .err_illegal(err_illegal), .load_count(load_count)
  );

  // Synchronous memory; bus carries junk when not being read so a missing hold register shows.
  always @(posedge clk) mem_rdata <= mem_rd_en ? mem[mem_addr] : 16'($urandom);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [20:0] model(input logic [3:0] f, input logic [3:0] rd, input logic [15:0] w);
    logic [7:0]  lo, hi;
    logic [15:0] d;
    logic        ill;
    lo = w[7:0]; hi = w[15:8]; d = 16'h0000; ill = 1'b0;
    if (f == 4'd0)      d = w;
    else if (f == 4'd1) d = {8'h00, lo};
    else if (f == 4'd2) d = {8'h00, hi};
    else if (f == 4'd3) d = {(lo[7] ? 8'hFF : 8'h00), lo};
    else if (f == 4'd4) d = {(hi[7] ? 8'hFF : 8'h00), hi};
    else                ill = 1'b1;
    return {ill, rd, d};
  endfunction

  // Monitor: pop/compare retiring ops, then push newly accepted ones.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb.delete();
        run = 0;
      end else begin
        if (mem_rd_en) rd_cnt++;
        if (rf_we && rf_ready) begin
          we_cnt++; run++;
          if (run > max_run) max_run = run;
          if (sb.size() == 0) check_eq("wr_unexpected", 32'd1, 32'd0);
          else begin
            e = sb.pop_front();
            check_eq("wr_result", {11'd0, 1'b0, rf_waddr, rf_wdata}, {11'd0, e});
          end
        end else run = 0;
        if (err_illegal) begin
          err_cnt++;
          if (sb.size() == 0) check_eq("err_unexpected", 32'd1, 32'd0);
          else begin
            e = sb.pop_front();
            check_eq("err_is_illegal", {31'd0, err_illegal}, {31'd0, e[20]});
          end
        end
        if (in_valid && in_ready) sb.push_back(model(in_func, in_rd, mem[in_addr]));
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic drive_op(input logic [3:0] rd, input logic [3:0] f, input logic [7:0] a);
    int n;
    n = 0;
    in_valid = 1'b1; in_rd = rd; in_func = f; in_addr = a;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) check_eq("accept_timeout", 32'd0, 32'd1);
    next_cycle();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check_eq("drain", sb.size(), 32'd0);
    next_cycle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, r0, w0, e0, acc;
    logic rdy;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[8'h10] = 16'hA5F0;
    rst_n = 1'b0; in_valid = 1'b0; in_rd = 4'd0; in_func = 4'd0; in_addr = 8'd0; rf_ready = 1'b1;
    repeat (2) next_cycle();
    @(negedge clk);
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("rst_mem_rd_en", {31'd0, mem_rd_en}, 32'd0);
    check_eq("rst_rf_we", {31'd0, rf_we}, 32'd0);
    check_eq("rst_err", {31'd0, err_illegal}, 32'd0);
    check_eq("rst_waddr", {28'd0, rf_waddr}, 32'd0);
    check_eq("rst_wdata", {16'd0, rf_wdata}, 32'd0);
    check_eq("rst_count", {16'd0, load_count}, 32'd0);
    next_cycle();
    rst_n = 1'b1;

    // Single full-word load and its latency
    r0 = rd_cnt;
    drive_op(4'd3, 4'd0, 8'h10);
    @(negedge clk);
    check_eq("lat_rd_en", {31'd0, mem_rd_en}, 32'd1);
    check_eq("lat_mem_addr", {24'd0, mem_addr}, 32'h10);
    next_cycle();
    @(negedge clk);
    check_eq("lat_no_we_c2", {31'd0, rf_we}, 32'd0);
    next_cycle();
    @(negedge clk);
    check_eq("lat_we_c3", {31'd0, rf_we}, 32'd1);
    check_eq("lat_waddr", {28'd0, rf_waddr}, 32'd3);
    check_eq("lat_wdata", {16'd0, rf_wdata}, 32'h0000A5F0);
    next_cycle();
    @(negedge clk);
    check_eq("lat_count", {16'd0, load_count}, 32'd1);
    check_eq("lat_reads", rd_cnt - r0, 32'd1);
    next_cycle();

    // Byte formats of A5F0
    c0 = load_count;
    drive_op(4'd4, 4'd1, 8'h10);
    drive_op(4'd5, 4'd2, 8'h10);
    drive_op(4'd6, 4'd3, 8'h10);
    drive_op(4'd7, 4'd4, 8'h10);
    drain();
    check_eq("fmt_count", load_count, c0 + 4);

    // Eight back-to-back loads, same rd on the last two
    c0 = load_count; r0 = rd_cnt; max_run = 0;
    for (int i = 0; i < 8; i++) drive_op((i < 7) ? 4'(i) : 4'd6, 4'(i % 5), 8'(8'h20 + i));
    drain();
    check_eq("b2b_run", max_run, 32'd8);
    check_eq("b2b_count", load_count, c0 + 8);
    check_eq("b2b_reads", rd_cnt - r0, 32'd8);

    // Backpressure: rf_ready low for 6 cycles while streaming
    c0 = load_count; r0 = rd_cnt; acc = 0; rdy = 1'b0;
    rf_ready = 1'b0;
    in_valid = 1'b1; in_rd = 4'd8; in_func = 4'd0; in_addr = 8'h40;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      rdy = in_ready;
      if (rdy) acc++;
      next_cycle();
      if (rdy) begin
        in_rd = 4'(8 + acc); in_func = 4'(acc % 5); in_addr = 8'(8'h40 + acc);
      end
    end
    check_eq("bp_accepted", acc, 32'd3);
    check_eq("bp_in_ready_low", {31'd0, rdy}, 32'd0);
    rf_ready = 1'b1;
    for (int i = acc; i < 6; i++) drive_op(4'(8 + i), 4'(i % 5), 8'(8'h40 + i));
    drain();
    check_eq("bp_count", load_count, c0 + 6);
    check_eq("bp_reads", rd_cnt - r0, 32'd6);

    // Illegal func followed by a normal op
    c0 = load_count; e0 = err_cnt;
    drive_op(4'd9, 4'hF, 8'h10);
    drive_op(4'd10, 4'd0, 8'h11);
    drain();
    check_eq("ill_pulses", err_cnt - e0, 32'd1);
    check_eq("ill_count", load_count, c0 + 1);

    // Reset with three ops in flight
    rf_ready = 1'b0;
    drive_op(4'd1, 4'd0, 8'h50);
    drive_op(4'd2, 4'd0, 8'h51);
    drive_op(4'd3, 4'd0, 8'h52);
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1; rf_ready = 1'b1; w0 = we_cnt;
    repeat (10) next_cycle();
    @(negedge clk);
    check_eq("rstfl_no_we", we_cnt - w0, 32'd0);
    check_eq("rstfl_count", {16'd0, load_count}, 32'd0);
    check_eq("rstfl_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("rstfl_sb_empty", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
